// File: rtl/tts_pkg.sv
// tts_pkg: shared state encoding and width helpers for the truth-table sweeper.
package tts_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} tts_state_e;
  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction
  function automatic int cnt_w(input int s);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction
endpackage

// File: rtl/tts_settle_timer.sv
// tts_settle_timer: counts 0..SETTLE-1 while enabled and flags the sample cycle.
module tts_settle_timer
  import tts_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CW = cnt_w(SETTLE);
  logic [CW-1:0] cnt;
  assign tick = en && (cnt == CW'(SETTLE - 1));
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all input vectors and captures f_in into a truth table.
// Define TTS_MINTERM_COUNT_EN to add the ones_count minterm counter.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     f_in,
  output logic [N_IN-1:0]          stim,
  output logic                     busy,
  output logic                     done,
`ifdef TTS_MINTERM_COUNT_EN
  output logic [N_IN:0]            ones_count,
`endif
  output logic [tbl_w(N_IN)-1:0]   truth_table
);
  tts_state_e state;
  logic       tick;
  logic       start_ok;
  assign start_ok = start && (state != DRIVE);
  assign busy     = (state == DRIVE);
  assign done     = (state == DONE);
  tts_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(start_ok),
    .en   (busy),
    .tick (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stim        <= '0;
      truth_table <= '0;
    end else if (start_ok) begin
      state       <= DRIVE;
      stim        <= '0;
      truth_table <= '0;
    end else if (busy && tick) begin
      truth_table[stim] <= f_in;
      state             <= (stim == '1) ? DONE : DRIVE;
      stim              <= (stim == '1) ? stim : stim + 1'b1;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
`ifdef TTS_MINTERM_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) ones_count <= '0;
    else if (busy && tick) ones_count <= ones_count + (N_IN + 1)'(f_in);
  end
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven sweeps with a scoreboard queue of expected tables.
module tb_truth_table_sweeper;
  logic        clk = 0;
  logic        rst = 1;
  logic        start_a = 0, start_b = 0;
  logic        f_a;
  logic [3:0]  stim_a;
  logic [2:0]  stim_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] table_a;
  logic [7:0]  table_b;
`ifdef TTS_MINTERM_COUNT_EN
  logic [4:0]  ones_a;
  logic [3:0]  ones_b;
`endif
  int errors = 0, checks = 0;
  int mode = 0, ph = 0;
  logic [15:0] sb_t[$];
  int          sb_o[$];

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .f_in(f_a), .stim(stim_a),
    .busy(busy_a), .done(done_a),
`ifdef TTS_MINTERM_COUNT_EN
    .ones_count(ones_a),
`endif
    .truth_table(table_a)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .f_in(1'b1), .stim(stim_b),
    .busy(busy_b), .done(done_b),
`ifdef TTS_MINTERM_COUNT_EN
    .ones_count(ones_b),
`endif
    .truth_table(table_b)
  );

  function automatic logic fn(input logic [3:0] s);
    return (s[3] ^ s[2]) & (s[1] | ~s[0]);
  endfunction

  // Independent settle-phase model: ph == 1 marks the last cycle a vector is held.
  always @(posedge clk) ph <= (rst || !busy_a || ph == 1) ? 0 : ph + 1;

  assign f_a = (mode == 0) ? fn(stim_a) :
               (mode == 1) ? ((ph == 1) ? fn(stim_a) : ~fn(stim_a)) :
               (mode == 2) ? 1'b0 :
               (mode == 3) ? 1'b1 : ~fn(stim_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sweep_a(input int m, input logic [15:0] et, input int eo, input bit hold);
    int bc, n;
    logic [15:0] t;
    int o;
    mode = m;
    sb_t.push_back(et);
    sb_o.push_back(eo);
    start_a = 1;
    @(negedge clk);
    if (!hold) start_a = 0;
    chk("start_busy", busy_a, 1);
    chk("start_stim", stim_a, 0);
    chk("start_done_low", done_a, 0);
    bc = 1;
    n = 0;
    while (!done_a && n < 400) begin
      @(negedge clk);
      if (busy_a) bc++;
      n++;
    end
    chk("done_seen", done_a, 1);
    chk("busy_cycles", bc, 32);
    chk("done_busy_low", busy_a, 0);
    t = sb_t.pop_front();
    o = sb_o.pop_front();
    chk("table_a", table_a, t);
`ifdef TTS_MINTERM_COUNT_EN
    chk("ones_a", ones_a, o);
`else
    if (o < 0) $display("unexpected negative count");
`endif
  endtask

  typedef struct {
    int          mode;
    logic [15:0] tbl;
    int          ones;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int n, bc;
    vecs[0] = '{0, 16'h0DD0, 6};
    vecs[1] = '{1, 16'h0DD0, 6};
    vecs[2] = '{2, 16'h0000, 0};
    vecs[3] = '{3, 16'hFFFF, 16};
    vecs[4] = '{4, 16'hF22F, 10};
    repeat (3) @(negedge clk);
    chk("rst_stim", stim_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_table", table_a, 0);
    rst = 0;
    @(negedge clk);
    foreach (vecs[i]) begin
      sweep_a(vecs[i].mode, vecs[i].tbl, vecs[i].ones, 0);
      @(negedge clk);
      chk("done_pulse_one", done_a, 0);
      chk("table_hold", table_a, vecs[i].tbl);
    end
    // Start held high: back-to-back sweeps, starts during DRIVE ignored.
    sweep_a(0, 16'h0DD0, 6, 1);
    sweep_a(4, 16'hF22F, 10, 1);
    sweep_a(0, 16'h0DD0, 6, 0);
    @(negedge clk);
    chk("b2b_idle", busy_a, 0);
    // Reset mid-sweep at stim 5.
    mode = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    n = 0;
    while (stim_a != 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_stim5", stim_a, 5);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_stim", stim_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_table", table_a, 0);
`ifdef TTS_MINTERM_COUNT_EN
    chk("mid_rst_ones", ones_a, 0);
`endif
    start_a = 1;
    @(negedge clk);
    chk("rst_start_busy", busy_a, 0);
    rst = 0;
    start_a = 0;
    @(negedge clk);
    chk("post_rst_idle", busy_a, 0);
    sweep_a(0, 16'h0DD0, 6, 0);
    // Narrow instance: N_IN=3, SETTLE=1, f_in tied high.
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    chk("b_start_busy", busy_b, 1);
    bc = 1;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      if (busy_b) bc++;
      n++;
    end
    chk("b_done", done_b, 1);
    chk("b_busy_cycles", bc, 8);
    chk("b_table", table_b, 8'hFF);
    chk("b_stim_hold", stim_b, 7);
`ifdef TTS_MINTERM_COUNT_EN
    chk("b_ones", ones_b, 8);
`endif
    @(negedge clk);
    chk("b_done_pulse", done_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
